// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
// Holds the opcode constants, the 8-bit control bundle layout, the bundle values the
// decoder produces (including the all-zero bubble), the trimmed ID/EX payload and the
// multiply FSM state encoding.
package ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcNone   = 7'b0000000;
  localparam logic [6:0] Funct7Mul = 7'b0000001;

  // Bit order {aluop[1:0], alusrc, branch, memread, memwrite, regwrite, memtoreg}.
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = 8'b00_0_0_0_0_0_0;
  localparam ctrl_t CtrlR      = 8'b10_0_0_0_0_1_0;
  localparam ctrl_t CtrlIAlu   = 8'b11_1_0_0_0_1_0;
  localparam ctrl_t CtrlLoad   = 8'b00_1_0_1_0_1_1;
  localparam ctrl_t CtrlStore  = 8'b00_1_0_0_1_0_0;
  localparam ctrl_t CtrlBranch = 8'b01_0_1_0_0_0_0;

  // ID/EX payload: branch resolves in ID, so only the later-stage fields plus mul travel on.
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       mul;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } idex_t;

  localparam idex_t IdexBubble = '0;

  typedef enum logic {StIdle, StBusy} mul_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 decoder for the ID stage.
// Ports:
//   opcode_i  - instruction bits [6:0]
//   funct7_i  - instruction bits [31:25]
//   ctrl_o    - 8-bit control bundle (bubble for 0000000 and unknown opcodes)
//   mul_o     - R-type multiply (only when CTRL_MUL_EN is defined)
//   illegal_o - unknown opcode, or multiply when CTRL_MUL_EN is undefined
// Configuration macro: CTRL_MUL_EN enables multiply decode.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       mul_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CtrlBubble;
    mul_o     = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OpcR: begin
        if (funct7_i == Funct7Mul) begin
`ifdef CTRL_MUL_EN
          ctrl_o = CtrlR;
          mul_o  = 1'b1;
`else
          illegal_o = 1'b1;
`endif
        end else begin
          ctrl_o = CtrlR;
        end
      end
      OpcIAlu:   ctrl_o = CtrlIAlu;
      OpcLoad:   ctrl_o = CtrlLoad;
      OpcStore:  ctrl_o = CtrlStore;
      OpcBranch: ctrl_o = CtrlBranch;
      OpcNone:   ctrl_o = CtrlBubble;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the IF/ID instruction, carries control through the
// ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards and sequences multiplies.
// Ports:
//   clk_i, rst_n_i            - clock, asynchronous active-low reset
//   inst_i                    - instruction in IF/ID
//   flush_i                   - taken-branch flush of the ID instruction
//   branch_o                  - ID branch decode, gated by bubble conditions
//   stall_o                   - hold PC and IF/ID
//   ex_ctrl_o                 - {aluop[1:0], alusrc, mul}
//   mem_ctrl_o                - {memread, memwrite}
//   wb_ctrl_o                 - {regwrite, memtoreg}
//   ex_rd_o, mem_rd_o, wb_rd_o - per-stage destination register
//   illegal_o                 - unknown opcode in ID
//   mul_busy_o                - multiply FSM in BUSY
// Configuration macro: CTRL_MUL_EN adds multiply decode, FSM and counter.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       inst_i,
  input  logic              flush_i,
  output logic              branch_o,
  output logic              stall_o,
  output logic [3:0]        ex_ctrl_o,
  output logic [1:0]        mem_ctrl_o,
  output logic [1:0]        wb_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              illegal_o,
  output logic              mul_busy_o
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              unused_funct3;

  assign opcode        = inst_i[6:0];
  assign rd            = REG_AW'(inst_i[11:7]);
  assign rs1           = REG_AW'(inst_i[19:15]);
  assign rs2           = REG_AW'(inst_i[24:20]);
  assign unused_funct3 = ^inst_i[14:12];

  ctrl_t dec_ctrl;
  logic  dec_mul, dec_illegal;

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .funct7_i  (inst_i[31:25]),
    .ctrl_o    (dec_ctrl),
    .mul_o     (dec_mul),
    .illegal_o (dec_illegal)
  );

  idex_t             idex_q, idex_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic [3:0]        exmem_ctrl_q, exmem_ctrl_d; // {memread, memwrite, regwrite, memtoreg}
  logic [1:0]        memwb_ctrl_q, memwb_ctrl_d; // {regwrite, memtoreg}

  // Load-use hazard against the instruction in EX.
  logic use_rs1, use_rs2, load_use;
  assign use_rs1  = (dec_ctrl != CtrlBubble);
  assign use_rs2  = use_rs1 && (opcode == OpcR || opcode == OpcStore || opcode == OpcBranch);
  assign load_use = idex_q.memread && (ex_rd_q != '0) &&
                    ((use_rs1 && (ex_rd_q == rs1)) || (use_rs2 && (ex_rd_q == rs2)));

  // mul_hold is high in every cycle after which the multiply must still sit in EX: the
  // IDLE cycle that launches it and every BUSY cycle except the last one.
  logic mul_hold, mul_busy;

`ifdef CTRL_MUL_EN
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mul_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic           mul_start;

  assign mul_start = (state_q == StIdle) && idex_q.mul && (MUL_LAT > 1);
  assign mul_hold  = mul_start || ((state_q == StBusy) && (cnt_q != CntW'(1)));
  assign mul_busy  = (state_q == StBusy);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_q <= StBusy;
            cnt_q   <= CntW'(MUL_LAT - 1);
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StIdle;
        end
      endcase
    end
  end
`else
  assign mul_hold = 1'b0;
  assign mul_busy = 1'b0;
`endif

  always_comb begin
    idex_d  = idex_q;
    ex_rd_d = ex_rd_q;
    if (!mul_hold) begin
      if (flush_i || load_use) begin
        idex_d  = IdexBubble;
        ex_rd_d = '0;
      end else begin
        idex_d.aluop    = dec_ctrl.aluop;
        idex_d.alusrc   = dec_ctrl.alusrc;
        idex_d.mul      = dec_mul;
        idex_d.memread  = dec_ctrl.memread;
        idex_d.memwrite = dec_ctrl.memwrite;
        idex_d.regwrite = dec_ctrl.regwrite;
        idex_d.memtoreg = dec_ctrl.memtoreg;
        // Only writers carry a destination; stores/branches reuse those bits as immediate.
        ex_rd_d         = dec_ctrl.regwrite ? rd : '0;
      end
    end

    if (mul_hold) begin
      exmem_ctrl_d = '0;
      mem_rd_d     = '0;
    end else begin
      exmem_ctrl_d = {idex_q.memread, idex_q.memwrite, idex_q.regwrite, idex_q.memtoreg};
      mem_rd_d     = ex_rd_q;
    end

    memwb_ctrl_d = exmem_ctrl_q[1:0];
    wb_rd_d      = mem_rd_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q       <= IdexBubble;
      ex_rd_q      <= '0;
      exmem_ctrl_q <= '0;
      mem_rd_q     <= '0;
      memwb_ctrl_q <= '0;
      wb_rd_q      <= '0;
    end else begin
      idex_q       <= idex_d;
      ex_rd_q      <= ex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      mem_rd_q     <= mem_rd_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      wb_rd_q      <= wb_rd_d;
    end
  end

  assign branch_o   = dec_ctrl.branch && !flush_i && !load_use && !mul_hold;
  assign stall_o    = mul_hold || load_use;
  assign illegal_o  = dec_illegal;
  assign mul_busy_o = mul_busy;
  assign ex_ctrl_o  = {idex_q.aluop, idex_q.alusrc, idex_q.mul};
  assign mem_ctrl_o = exmem_ctrl_q[3:2];
  assign wb_ctrl_o  = memwb_ctrl_q;
  assign ex_rd_o    = ex_rd_q;
  assign mem_rd_o   = mem_rd_q;
  assign wb_rd_o    = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit (REG_AW = 5, MUL_LAT = 4).
module tb_ctrl_pipe_unit;

  localparam int unsigned RegAw  = 5;
  localparam int unsigned MulLat = 4;

  localparam logic [31:0] InstAddi1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] InstAdd3  = 32'h001101B3; // add  x3,x2,x1
  localparam logic [31:0] InstLw2   = 32'h00002103; // lw   x2,0(x0)
  localparam logic [31:0] InstLw0   = 32'h00002003; // lw   x0,0(x0)
  localparam logic [31:0] InstAdd4  = 32'h00000233; // add  x4,x0,x0
  localparam logic [31:0] InstSw    = 32'h00112023; // sw   x1,0(x2)
  localparam logic [31:0] InstSwX2  = 32'h00202023; // sw   x2,0(x0)
  localparam logic [31:0] InstAddi5 = 32'h00200293; // addi x5,x0,2
  localparam logic [31:0] InstBeq   = 32'h02000063; // beq  x0,x0,32
  localparam logic [31:0] InstBeqX2 = 32'h02010063; // beq  x2,x0,32
  localparam logic [31:0] InstMul   = 32'h027302B3; // mul  x5,x6,x7
  localparam logic [31:0] InstBad   = 32'h0000007F;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [31:0]      inst_i;
  logic             flush_i;
  logic             branch_o, stall_o, illegal_o, mul_busy_o;
  logic [3:0]       ex_ctrl_o;
  logic [1:0]       mem_ctrl_o, wb_ctrl_o;
  logic [RegAw-1:0] ex_rd_o, mem_rd_o, wb_rd_o;

  int checks   = 0;
  int failures = 0;

  ctrl_pipe_unit #(
    .REG_AW  (RegAw),
    .MUL_LAT (MulLat)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inst_i     (inst_i),
    .flush_i    (flush_i),
    .branch_o   (branch_o),
    .stall_o    (stall_o),
    .ex_ctrl_o  (ex_ctrl_o),
    .mem_ctrl_o (mem_ctrl_o),
    .wb_ctrl_o  (wb_ctrl_o),
    .ex_rd_o    (ex_rd_o),
    .mem_rd_o   (mem_rd_o),
    .wb_rd_o    (wb_rd_o),
    .illegal_o  (illegal_o),
    .mul_busy_o (mul_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] inst;
    logic        branch;
    logic        illegal;
    logic [3:0]  ex_ctrl;
    logic [4:0]  ex_rd;
  } vec_t;

  vec_t vecs[8];
  int   n_vecs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    inst_i  = 32'h0;
    flush_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
  endtask

  // Load in EX, consumer in ID: check the stall decision and branch gating.
  task automatic lu_probe(input string nm, input logic [31:0] ld, input logic [31:0] use_inst,
                          input logic exp_stall);
    inst_i = ld;
    tick();
    inst_i = use_inst;
    #1;
    check({nm, "_stall"}, stall_o, exp_stall);
    if (exp_stall) check({nm, "_branch_gated"}, branch_o, 1'b0);
    drain();
  endtask

  initial begin
    rst_n_i = 1'b0;
    inst_i  = 32'h0;
    flush_i = 1'b0;

    vecs[0] = '{InstAddi1, 1'b0, 1'b0, 4'b1110, 5'd1};
    vecs[1] = '{InstAdd3,  1'b0, 1'b0, 4'b1000, 5'd3};
    vecs[2] = '{InstLw2,   1'b0, 1'b0, 4'b0010, 5'd2};
    vecs[3] = '{InstSw,    1'b0, 1'b0, 4'b0010, 5'd0};
    vecs[4] = '{InstBeq,   1'b1, 1'b0, 4'b0100, 5'd0};
    vecs[5] = '{InstBad,   1'b0, 1'b1, 4'b0000, 5'd0};
    vecs[6] = '{32'h0,     1'b0, 1'b0, 4'b0000, 5'd0};
    n_vecs  = 7;
`ifndef CTRL_MUL_EN
    vecs[7] = '{InstMul,   1'b0, 1'b1, 4'b0000, 5'd0};
    n_vecs  = 8;
`endif

    // Reset state
    tick();
    tick();
    check("rst_stall", stall_o, 1'b0);
    check("rst_busy", mul_busy_o, 1'b0);
    check("rst_illegal", illegal_o, 1'b0);
    check("rst_ctrl", {ex_ctrl_o, mem_ctrl_o, wb_ctrl_o}, 8'h00);
    check("rst_rd", {ex_rd_o, mem_rd_o, wb_rd_o}, 15'h0);
    rst_n_i = 1'b1;
    tick();

    // addi flowing to WB
    inst_i = InstAddi1;
    tick();
    inst_i = 32'h0;
    check("addi_ex_ctrl", ex_ctrl_o, 4'b1110);
    check("addi_ex_rd", ex_rd_o, 5'd1);
    tick();
    check("addi_mem_ctrl", mem_ctrl_o, 2'b00);
    check("addi_mem_rd", mem_rd_o, 5'd1);
    tick();
    check("addi_wb_ctrl", wb_ctrl_o, 2'b10);
    check("addi_wb_rd", wb_rd_o, 5'd1);
    drain();

    // Decode table
    for (int i = 0; i < n_vecs; i++) begin
      inst_i = vecs[i].inst;
      #1;
      check($sformatf("v%0d_branch", i), branch_o, vecs[i].branch);
      check($sformatf("v%0d_illegal", i), illegal_o, vecs[i].illegal);
      check($sformatf("v%0d_stall", i), stall_o, 1'b0);
      tick();
      check($sformatf("v%0d_ex_ctrl", i), ex_ctrl_o, vecs[i].ex_ctrl);
      check($sformatf("v%0d_ex_rd", i), ex_rd_o, vecs[i].ex_rd);
      check($sformatf("v%0d_busy", i), mul_busy_o, 1'b0);
      inst_i = 32'h0;
      #1;
      check($sformatf("v%0d_illegal_clr", i), illegal_o, 1'b0);
      tick();
    end
    drain();

    // Load-use: one stall cycle, one bubble, add in EX two cycles after the lw
    inst_i = InstLw2;
    #1;
    check("lu_no_stall_first", stall_o, 1'b0);
    tick();
    inst_i = InstAdd3;
    #1;
    check("lu_stall", stall_o, 1'b1);
    tick();
    check("lu_bubble_ctrl", ex_ctrl_o, 4'b0000);
    check("lu_bubble_rd", ex_rd_o, 5'd0);
    check("lu_lw_in_mem", {mem_ctrl_o, mem_rd_o}, {2'b10, 5'd2});
    check("lu_stall_clr", stall_o, 1'b0);
    tick();
    check("lu_add_ex_ctrl", ex_ctrl_o, 4'b1000);
    check("lu_add_ex_rd", ex_rd_o, 5'd3);
    drain();

    lu_probe("lu_x0", InstLw0, InstAdd4, 1'b0);
    lu_probe("lu_irs2", InstLw2, InstAddi5, 1'b0);
    lu_probe("lu_store", InstLw2, InstSwX2, 1'b1);
    lu_probe("lu_beq", InstLw2, InstBeqX2, 1'b1);

    // Flush
    inst_i  = InstBeq;
    flush_i = 1'b1;
    #1;
    check("flush_branch_gated", branch_o, 1'b0);
    flush_i = 1'b0;
    #1;
    check("beq_branch", branch_o, 1'b1);
    tick();
    check("beq_ex_ctrl", ex_ctrl_o, 4'b0100);
    inst_i  = InstAddi1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    inst_i  = 32'h0;
    check("flush_ex_ctrl", ex_ctrl_o, 4'b0000);
    check("flush_ex_rd", ex_rd_o, 5'd0);
    drain();

`ifdef CTRL_MUL_EN
    begin
      int busy_n = 0;
      int stall_n = 0;
      int bub_n = 0;
      int seen = 0;
      inst_i = InstMul;
      tick();
      inst_i = InstAddi1;
      for (int k = 1; k <= 6; k++) begin
        #1;
        busy_n  += int'(mul_busy_o);
        stall_n += int'(stall_o);
        if (k >= 2 && k <= 4 && mem_rd_o == 5'd0 && mem_ctrl_o == 2'b00) bub_n++;
        if (k == 1) begin
          check("mul_ex_ctrl", ex_ctrl_o, 4'b1001);
          check("mul_ex_rd", ex_rd_o, 5'd5);
        end
        if (k == 2) flush_i = 1'b1;
        if (k == 3) begin
          check("mul_flush_ignored", ex_ctrl_o, 4'b1001);
          flush_i = 1'b0;
        end
        if (k == 5) begin
          check("mul_mem_rd", mem_rd_o, 5'd5);
          check("mul_follower_ex_rd", ex_rd_o, 5'd1);
        end
        if (k == 6) begin
          check("mul_wb_rd", wb_rd_o, 5'd5);
          check("mul_wb_ctrl", wb_ctrl_o, 2'b10);
        end
        tick();
        if (k == 4) inst_i = 32'h0;
      end
      check("mul_busy_cycles", busy_n, 3);
      check("mul_stall_cycles", stall_n, 3);
      check("mul_bubbles_mem", bub_n, 3);
      drain();

      // Reset during BUSY aborts the multiply
      inst_i = InstMul;
      tick();
      inst_i = 32'h0;
      tick();
      #1;
      check("rstmul_busy_before", mul_busy_o, 1'b1);
      rst_n_i = 1'b0;
      #1;
      check("rstmul_busy", mul_busy_o, 1'b0);
      check("rstmul_stall", stall_o, 1'b0);
      check("rstmul_ex_ctrl", ex_ctrl_o, 4'b0000);
      tick();
      rst_n_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
        if (mem_rd_o == 5'd5 || wb_rd_o == 5'd5) seen = 1;
        tick();
      end
      check("rstmul_never_mem", seen, 0);
    end
`else
    inst_i = InstMul;
    tick();
    inst_i = 32'h0;
    #1;
    check("nomul_busy", mul_busy_o, 1'b0);
    check("nomul_stall", stall_o, 1'b0);
    check("nomul_ex_ctrl", ex_ctrl_o, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
